mul_seq_ctrl: RTL
=================

// Module: mul_seq_ctrl
// PURPOSE
//  Sequencer for an unsigned shift-add multiplier built around the shared 32-bit CLA adder (ALU).
//  Each RUN cycle it drives the ALU operands, captures {Carry, Result} and shifts the 2*WIDTH
//  product register right. The ALU is external and purely combinational; this block owns all state.
//  Sits between the top-level multiplier wrapper (start/done handshake) and the ALU instance.
// PARAMETERS
//  WIDTH  32  operand width; must equal the ALU width (32)
//  CNT_W  6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk           in   1        clock, all state updates on rising edge
//  rst           in   1        synchronous reset, active-high
//  start         in   1        request; sampled only in IDLE
//  multiplicand  in   WIDTH    operand A, sampled on the edge that accepts start
//  multiplier    in   WIDTH    operand B, sampled on the edge that accepts start
//  alu_src1      out  WIDTH    to ALU Src_1: product[2*WIDTH-1:WIDTH]
//  alu_src2      out  WIDTH    to ALU Src_2: product[0] ? mcand_q : 0
//  alu_result    in   WIDTH    from ALU Result
//  alu_carry     in   1        from ALU Carry
//  busy          out  1        high in RUN
//  done          out  1        one-cycle pulse in DONE
//  product       out  2*WIDTH  result register; valid from done until next accepted start
// BEHAVIOUR
//  Reset: state=IDLE, count=0, product=0, mcand_q=0, busy=0, done=0. Overrides every other input,
//   including mid-RUN; the partial product is discarded, and no done pulse follows.
//  States:
//   IDLE: start=1 -> RUN; mcand_q<=multiplicand; product<={0,multiplier}; count<=0.
//   RUN: one step per clock:
//    product <= {alu_carry, alu_result, product[WIDTH-1:1]}; count<=count+1.
//    On the step with count==WIDTH-1 -> DONE.
//   DONE: done=1 for exactly one cycle -> IDLE unconditionally.
//  Handshake:
//   - start is ignored in RUN and DONE (no queueing), and operand inputs are ignored outside acceptance.
//   - start held high is re-accepted on the first IDLE cycle after DONE.
//  Latency: done is high in the cycle after the (WIDTH+1)th rising edge counted from the edge that
//   accepts start (edge 0 = accept, edges 1..WIDTH = steps). Back-to-back throughput is WIDTH+2 clocks
//   per multiply.
//  Arithmetic: unsigned; the carry from the ALU becomes product MSB before shift, so no overflow is lost.
//   alu_src2=0 when product[0]=0, so the upper half passes through the ALU unchanged (add zero).
//  Outputs alu_src1/alu_src2 are combinational from registers; their values outside RUN are don't-care,
//   but they remain driven (no X).
//  product holds its final value through DONE and IDLE until the next accepted start overwrites it.
//  busy=1 exactly for WIDTH cycles per operation; busy and done are never high together.
// TESTING
//  1. rst=1 two cycles with start=1 -> busy=0, done=0, product=0, state stays IDLE.
//  2. start, A=3, B=5 -> done after 33 clocks, product=64'h0000_0000_0000_000F; busy high 32 cycles.
//  3. A=32'hFFFF_FFFF, B=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001 (carry path exercised).
//  4. A=0, B=32'hDEAD_BEEF, then A=32'h1234_5678, B=0 -> product=0 both; done pulses once each.
//  5. start A=7,B=9; pulse start with A=2,B=2 mid-RUN -> ignored, product=64'd63; then rst at step 10
//     of a new op -> IDLE, product=0, no done.
//  6. start held high continuously with A=6, B=7 -> done every 34 clocks, product=64'd42 each time.

Source files
------------

// File: rtl/mul_seq_ctrl_if.sv
// Handshake and ALU-side bus of the shift-add multiply sequencer.
// slave = the sequencer itself; master = the wrapper/ALU environment around it.
interface mul_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [WIDTH-1:0]   alu_src1;
  logic [WIDTH-1:0]   alu_src2;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_carry;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport slave (
    input  start, multiplicand, multiplier, alu_result, alu_carry,
    output alu_src1, alu_src2, busy, done, product
  );

  modport master (
    output start, multiplicand, multiplier, alu_result, alu_carry,
    input  alu_src1, alu_src2, busy, done, product
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequencer for an unsigned shift-add multiplier using an external combinational adder.
// One add-and-shift step per clock in RUN; {carry, sum} becomes the new product top half.
module mul_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  mul_seq_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   count_r, count_s;
  logic [2*WIDTH-1:0] product_r, product_s;
  logic [WIDTH-1:0]   mcand_r, mcand_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_s   = state_r;
    count_s   = count_r;
    product_s = product_r;
    mcand_s   = mcand_r;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s   = ST_RUN;
          mcand_s   = bus.multiplicand;
          product_s = {{WIDTH{1'b0}}, bus.multiplier};
          count_s   = {CNT_W{1'b0}};
          busy_s    = 1'b1;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Carry lands in the MSB before the shift, so no overflow bit is lost
        product_s = {bus.alu_carry, bus.alu_result, product_r[WIDTH-1:1]};
        count_s   = count_r + CNT_W'(1);
        if (count_r == CNT_W'(WIDTH - 1)) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
        end else begin
          busy_s  = 1'b1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      count_r   <= {CNT_W{1'b0}};
      product_r <= {(2*WIDTH){1'b0}};
      mcand_r   <= {WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      count_r   <= count_s;
      product_r <= product_s;
      mcand_r   <= mcand_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign bus.alu_src1 = product_r[2*WIDTH-1:WIDTH];
  assign bus.alu_src2 = product_r[0] ? mcand_r : {WIDTH{1'b0}};
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.product  = product_r;

endmodule
